// File: rtl/ram_bist_ctrl.sv
// RAM built-in self-test controller: writes a pattern, reads it back, then repeats with the
// inverted pattern, counting read-back mismatches and remembering the first failing address.
module ram_bist_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enb,
  output logic                  read_enb,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR0   = 3'd1;
  localparam logic [2:0] S_RD0   = 3'd2;
  localparam logic [2:0] S_WR1   = 3'd3;
  localparam logic [2:0] S_RD1   = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [7:0]            err_q, err_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic                  last_addr;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pattern_at(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic inv);
    logic [DATA_WIDTH-1:0] v;
    v = PATTERN ^ DATA_WIDTH'(a);
    return inv ? ~v : v;
  endfunction

  assign last_addr = (addr_q == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR0;
          addr_d  = '0;
        end
      end
      S_WR0: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (last_addr) state_d = S_RD0;
      end
      S_RD0: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (last_addr) state_d = S_WR1;
      end
      S_WR1: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (last_addr) state_d = S_RD1;
      end
      S_RD1: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (last_addr) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so every RAM-facing output comes off a flop.
  always_comb begin
    we_d       = (state_d == S_WR0) || (state_d == S_WR1);
    re_d       = (state_d == S_RD0) || (state_d == S_RD1);
    busy_d     = (state_d != S_IDLE);
    addr_out_d = (we_d || re_d) ? addr_d : '0;
    data_in_d  = we_d ? pattern_at(addr_d, state_d == S_WR1) : '0;
  end

  // The read issued last cycle returns data now; compare it one cycle later regardless of state.
  always_comb begin
    cmp_valid_d = re_q;
    exp_d       = pattern_at(addr_out_q, state_q == S_RD1);
    cmp_addr_d  = addr_out_q;
    mismatch    = cmp_valid_q && (data_out != exp_q);
    err_d       = err_q;
    ffa_d       = ffa_q;
    done_d      = done_q;
    pass_d      = pass_q;
    if ((state_q == S_IDLE) && start) begin
      err_d  = '0;
      ffa_d  = '0;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else if (mismatch) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (err_q == 8'd0)  ffa_d = cmp_addr_q;
    end
    if (state_q == S_CHECK) begin
      done_d = 1'b1;
      pass_d = (err_d == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      addr_out_q  <= '0;
      data_in_q   <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ffa_q       <= '0;
      cmp_valid_q <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_out_q  <= addr_out_d;
      data_in_q   <= data_in_d;
      we_q        <= we_d;
      re_q        <= re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ffa_q       <= ffa_d;
      cmp_valid_q <= cmp_valid_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign data_in         = data_in_q;
  assign address         = addr_out_q;
  assign write_enb       = we_q;
  assign read_enb        = re_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM word width; SHALL be >= ADDR_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 4, RAM address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter PATTERN, default 8'hA5 (zero-extended to DATA_WIDTH), base test pattern.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to run one test; sampled only in IDLE.
REQ-007 data_out  input  DATA_WIDTH  read data returned by the RAM.
REQ-008 data_in  output  DATA_WIDTH  write data to the RAM.
REQ-009 address  output  ADDR_WIDTH  RAM address.
REQ-010 write_enb  output  1  RAM write strobe.
REQ-011 read_enb  output  1  RAM read strobe.
REQ-012 busy  output  1  high while a test runs (any state other than IDLE).
REQ-013 done  output  1  high from test completion until the next accepted start.
REQ-014 pass  output  1  valid while done=1; 1 = no mismatches.
REQ-015 err_count  output  8  mismatch count, saturating at 255.
REQ-016 first_fail_addr  output  ADDR_WIDTH  address of the first mismatch; 0 if none.

Function
REQ-017 RAM contract: write when write_enb=1 at the edge; registered read: data_out holds mem[address] from the edge after the read_enb=1 edge until the next read.
REQ-018 States: IDLE, WR0, RD0, WR1, RD1, CHECK.
REQ-019 IDLE: write_enb=read_enb=0, address=0, data_in=0; start=1 -> WR0; same edge clears done, pass, err_count and first_fail_addr, and sets address counter to 0.
REQ-020 WR0: write_enb=1, data_in = PATTERN ^ address (address zero-extended); address increments each cycle; at address DEPTH-1 -> RD0 with address wrapping to 0.
REQ-021 RD0: read_enb=1, address ascending 0..DEPTH-1; expected = PATTERN ^ address is registered alongside a compare-valid flag; at DEPTH-1 -> WR1 with address wrapping to 0.
REQ-022 WR1: as WR0 but data_in = ~(PATTERN ^ address); at DEPTH-1 -> RD1.
REQ-023 RD1: as RD0 with expected = ~(PATTERN ^ address); at DEPTH-1 -> CHECK.
REQ-024 The compare SHALL execute one cycle after each read, independent of the current state; the last RD0 compare occurs in the first WR1 cycle, and the last RD1 compare occurs in CHECK.
REQ-025 On a mismatch (data_out != expected), err_count increments (holds at 255).
REQ-026 On a mismatch, first_fail_addr is captured only when err_count was 0 before that compare.
REQ-027 CHECK: no RAM strobes; -> IDLE, setting done=1 and pass=(final err_count==0).
REQ-028 write_enb and read_enb SHALL never be high in the same cycle.
REQ-029 Latency: done rises on the edge 4*DEPTH+1 edges after the edge that sampled start (65 for DEPTH=16).
REQ-030 A start pulse outside IDLE SHALL be ignored, with no effect on state or results.
REQ-031 A start pulse in IDLE while done=1 SHALL begin a new test.
REQ-032 All outputs SHALL be driven from registers, with no combinational path from data_out or start.

Reset
REQ-033 reset=0 SHALL immediately force state=IDLE; write_enb=0; read_enb=0; address=0; data_in=0.
REQ-034 reset=0 SHALL also force busy=0, done=0, pass=0, err_count=0, first_fail_addr=0, and compare-valid=0.
REQ-035 Reset mid-test SHALL abort the test with no later compare or strobe; after release, the block waits in IDLE for start.

Verification
REQ-036 Good RAM with default parameters, start pulse -> 16 writes of A5^a, then 16 reads, then 16 writes of ~(A5^a), then 16 reads; done=1 and pass=1 at edge 65; err_count=0.
REQ-037 RAM model forcing data_out[0]=0 -> err_count=16 (8 in RD0 at even addresses, 8 in RD1 at odd addresses), first_fail_addr=0, pass=0.
REQ-038 Start re-pulsed at cycles 5 and 40 of a run -> ignored; done still rises at edge 65; exactly 64 RAM strobes.
REQ-039 reset driven low in the RD0 phase -> write_enb, read_enb and busy fall without waiting for clk; no further strobes; a later start runs a full test from address 0.
REQ-040 ADDR_WIDTH=8 with a RAM that returns all-zeros -> err_count saturates at 255, first_fail_addr=0, pass=0.
REQ-041 Second start while done=1 -> done and pass clear on the accepting edge; second result independent of the first.
